// File: rtl/ptp_ka10.sv
// KA10 paper tape punch: CONO/CONI/DATAO device with front-end frame handshake.
// Optional PTP_TAPE_FEED_EN adds key_tape_feed to punch blank leader frames.
module ptp_ka10 #(
   parameter logic [6:0] DEVNO       = 7'o20,
   parameter int         PUNCH_DELAY = 100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        iobus_iob_poweron,
   input  logic        iobus_iob_reset,
   input  logic        iobus_datao_clear,
   input  logic        iobus_datao_set,
   input  logic        iobus_cono_clear,
   input  logic        iobus_cono_set,
   input  logic        iobus_iob_fm_datai,
   input  logic        iobus_iob_fm_status,
   input  logic        iobus_rdi_pulse,
   input  logic [3:9]  iobus_ios,
   input  logic [0:35] iobus_iob_in,
   output logic [0:35] iobus_iob_out,
   output logic [1:7]  iobus_pi_req,
   output logic        iobus_dr_split,
   output logic        iobus_rdi_data,
`ifdef PTP_TAPE_FEED_EN
   input  logic        key_tape_feed,
`endif
   input  logic        s_read,
   output logic [31:0] s_readdata,
   output logic        fe_data_rq
);

   localparam int CW = (PUNCH_DELAY > 1) ? $clog2(PUNCH_DELAY) : 1;

   typedef enum logic [1:0] {IDLE, FE_WAIT, PUNCH} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [7:0]    frame, frame_n;
   logic          bin, bin_n;
   logic          busy, busy_n;
   logic          flag, flag_n;
   logic [2:0]    pia, pia_n;

   logic          sel, ld, clr;
   logic [7:0]    dv;

`ifdef PTP_TAPE_FEED_EN
   logic          feeding, feeding_n;
   logic          pend, pend_n;
   logic [7:0]    pend_data, pend_data_n;
`endif

   logic unused_ok;
   assign unused_ok = ^{iobus_datao_clear, iobus_rdi_pulse,
                        iobus_iob_fm_datai, iobus_iob_in[0:27],
                        iobus_iob_in[31]};

   assign sel = (iobus_ios == DEVNO);
   assign ld  = sel && iobus_datao_set && !busy;
   assign clr = !iobus_iob_poweron || iobus_iob_reset;
   assign dv  = bin ? {2'b10, iobus_iob_in[30:35]}
                    : iobus_iob_in[28:35];

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      frame_n = frame;
      bin_n   = bin;
      busy_n  = busy;
      flag_n  = flag;
      pia_n   = pia;
`ifdef PTP_TAPE_FEED_EN
      feeding_n   = feeding;
      pend_n      = pend;
      pend_data_n = pend_data;
`endif

      if (sel && iobus_cono_clear) begin
         bin_n  = 1'b0;
         flag_n = 1'b0;
         pia_n  = 3'd0;
      end
      if (sel && iobus_cono_set) begin
         bin_n  = bin_n  | iobus_iob_in[30];
         flag_n = flag_n | iobus_iob_in[32];
         pia_n  = pia_n  | iobus_iob_in[33:35];
      end

`ifdef PTP_TAPE_FEED_EN
      // DATAO landing mid feed-frame is parked until that frame ends
      if (ld && state != IDLE) begin
         pend_n      = 1'b1;
         pend_data_n = dv;
         busy_n      = 1'b1;
         flag_n      = 1'b0;
      end
`endif

      unique case (state)
         IDLE: begin
            if (ld) begin
               frame_n = dv;
               busy_n  = 1'b1;
               flag_n  = 1'b0;
               state_n = FE_WAIT;
            end
`ifdef PTP_TAPE_FEED_EN
            else if (key_tape_feed && !busy) begin
               frame_n   = 8'h00;
               feeding_n = 1'b1;
               state_n   = FE_WAIT;
            end
`endif
         end
         FE_WAIT: begin
            if (s_read) begin
               state_n = PUNCH;
               cnt_n   = CW'(PUNCH_DELAY - 1);
            end
         end
         PUNCH: begin
            if (cnt != '0) begin
               cnt_n = cnt - CW'(1);
            end else begin
               state_n = IDLE;
`ifdef PTP_TAPE_FEED_EN
               if (feeding) begin
                  feeding_n = 1'b0;
                  if (pend_n) begin
                     frame_n = pend_data_n;
                     pend_n  = 1'b0;
                     state_n = FE_WAIT;
                  end
               end else begin
                  busy_n = 1'b0;
                  flag_n = 1'b1;
               end
`else
               busy_n = 1'b0;
               flag_n = 1'b1;
`endif
            end
         end
         default: state_n = IDLE;
      endcase

      if (clr) begin
         state_n = IDLE;
         cnt_n   = '0;
         frame_n = 8'h00;
         bin_n   = 1'b0;
         busy_n  = 1'b0;
         flag_n  = 1'b0;
         pia_n   = 3'd0;
`ifdef PTP_TAPE_FEED_EN
         feeding_n   = 1'b0;
         pend_n      = 1'b0;
         pend_data_n = 8'h00;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         frame <= 8'h00;
         bin   <= 1'b0;
         busy  <= 1'b0;
         flag  <= 1'b0;
         pia   <= 3'd0;
`ifdef PTP_TAPE_FEED_EN
         feeding   <= 1'b0;
         pend      <= 1'b0;
         pend_data <= 8'h00;
`endif
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         frame <= frame_n;
         bin   <= bin_n;
         busy  <= busy_n;
         flag  <= flag_n;
         pia   <= pia_n;
`ifdef PTP_TAPE_FEED_EN
         feeding   <= feeding_n;
         pend      <= pend_n;
         pend_data <= pend_data_n;
`endif
      end
   end

   always_comb begin
      iobus_iob_out = '0;
      if (sel && iobus_iob_fm_status)
         iobus_iob_out = {30'd0, bin, busy, flag, pia};
   end

   always_comb begin
      iobus_pi_req = '0;
      for (int i = 1; i <= 7; i++)
         iobus_pi_req[i] = flag && (pia == 3'(i));
   end

   assign iobus_dr_split = 1'b0;
   assign iobus_rdi_data = 1'b0;
   assign s_readdata     = {24'd0, frame};
   assign fe_data_rq     = (state == FE_WAIT);

endmodule

// File: doc/ptp_ka10.md
# ptp_ka10

Paper tape punch for the KA10 I/O bus; it is the output counterpart of the `ptr_ka10` reader. CONO/CONI/DATAO from the CPU load an 8-bit frame and the punch presents it to the front end through a request/read handshake. It then models mechanical punch time, raises its done flag and requests a priority interrupt. It sits on the I/O bus beside `ptr_ka10`, and its `iobus_iob_out` is ORed into the CPU's `iobus_iob_in`.

## Interface
- `DEVNO`, default 7'o20: device number matched against `iobus_ios[3:9]`, giving device code 100.
- `PUNCH_DELAY`, default 100: clock cycles of simulated mechanism time after the front end takes a frame.
- `clk` in, 1: the single clock for the block.
- `reset` in, 1: asynchronous, active-high reset.
- `iobus_iob_poweron` in, 1: while low, the block is held in its reset state.
- `iobus_iob_reset` in, 1: one-cycle pulse that resets the block to its reset state.
- `iobus_datao_clear`, `iobus_datao_set`, `iobus_cono_clear`, `iobus_cono_set` in, 1 each: one-cycle strobes.
- `iobus_iob_fm_datai`, `iobus_iob_fm_status` in, 1 each: read levels for DATAI and CONI.
- `iobus_rdi_pulse` in, 1: ignored by the punch.
- `iobus_ios` in, [3:9]: device select.
- `iobus_iob_in` in, [0:35]: bus data from the CPU.
- `iobus_iob_out` out, [0:35]: read data, 0 when the device is not selected.
- `iobus_pi_req` out, [1:7]: priority interrupt request.
- `iobus_dr_split`, `iobus_rdi_data` out, 1 each: constant 0.
- `s_read` in, 1: front end takes the pending frame.
- `s_readdata` out, [31:0]: {24'b0, frame}.
- `fe_data_rq` out, 1: a frame is pending for the front end.

## Operation
- `sel` is true when `iobus_ios == DEVNO`. Every bus strobe is qualified by `sel`.
- Status register: `bin` (CONI bit 30), `busy` (bit 31), `flag` (bit 32), `pia[2:0]` (bits 33–35). CONI drives these six bits onto `iob_out[30:35]`; all other bits are 0. DATAI returns 0.
- CONO:
  - `cono_clear` zeroes `bin`, `flag` and `pia`.
  - `cono_set` ORs in `iob_in[30]` to `bin`, `iob_in[32]` to `flag` and `iob_in[33:35]` to `pia`.
  - Bit 31 is ignored; `busy` is never software-writable.
- DATAO:
  - `datao_clear` has no effect.
  - On `datao_set`, if `busy`=0: frame ← `bin` ? {2'b10, `iob_in[30:35]`} : `iob_in[28:35]`. At the same time `busy`←1, `flag`←0, and the state goes IDLE→FE_WAIT.
  - If `busy`=1, `datao_set` is ignored: the frame is unchanged and no state changes.
- State machine, IDLE / FE_WAIT / PUNCH:
  - FE_WAIT: `fe_data_rq`=1. On `s_read`=1, go to PUNCH and load the counter with `PUNCH_DELAY`-1.
  - PUNCH: decrement the counter. At 0, set `busy`←0 and `flag`←1, then go to IDLE.
  - `s_read` in IDLE or PUNCH is ignored. `s_readdata` always shows the frame register.
- PI: `iobus_pi_req[pia]` = `flag` when `pia` != 0; all other bits 0.
- Simultaneous events:
  - `cono_set` with bit 32 in the same cycle as the PUNCH terminal count leaves `flag`=1.
  - `cono_clear` in that same cycle still ends with `flag`=1, because completion has priority.
- Reset, `iob_reset`, or `iob_poweron` low, including mid-frame: state → IDLE, all status bits 0, frame 0, `fe_data_rq`=0, counter 0. A pending frame is discarded.

## Timing
- Reset values of all outputs are 0.
- Registers update on `posedge clk`. `iobus_iob_out` and `iobus_pi_req` are combinational from state and the select/read levels.
- `fe_data_rq` rises on the first clock after `datao_set`. It falls on the clock edge where `s_read`=1 is sampled.
- `flag` rises exactly `PUNCH_DELAY` clocks after the `s_read` edge; `busy` falls on the same edge.
- `PUNCH_DELAY` must be ≥ 1.

## Configuration
- `PTP_TAPE_FEED_EN`, compiled in:
  - Adds input `key_tape_feed`.
  - While it is held and the state is IDLE with `busy`=0, the block emits frame 8'h00 through FE_WAIT/PUNCH repeatedly, without touching `flag` or `busy`.
  - A DATAO arriving during a feed frame waits, with data latched, until that frame finishes.
- Not compiled in: no `key_tape_feed` port and no feed logic.

## Test plan
- Reset, then CONI (`ios`=7'o20, `fm_status`): `iob_out`=0 and `pi_req`=0.
- CONO 36'o000000000002 (pia=2, alpha), then DATAO 36'o000000000277: `fe_data_rq`=1; `s_read` pulse gives `s_readdata`=32'hBF; 100 clocks later CONI = 36'o000000000012 and `pi_req`=7'b0100000.
- CONO `bin`=1 (36'o000000000040), DATAO 36'o000000000077: frame = 8'hBF.
- A second DATAO while `busy`: frame is unchanged and `fe_data_rq` shows no new request.
- `iob_reset` pulse during PUNCH: `fe_data_rq`=0, CONI=0, and `flag` never sets.
- DATAO with `ios`=7'o21: no response at all.
